mem_arbiter: RTL and testbench

//  Shares one single-port memory between the CPU instruction-fetch port and its load/store data port.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_watchdog.sv | 48 ++++
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
// Purpose: FSM state encoding, requester port ids and the default poison word.
// Ports: none (package).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    localparam logic [31:0] DEFAULT_POISON = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - saturating access watchdog for the memory arbiter
// Purpose: counts cycles while enable is high; expire is raised in the cycle
//          whose count would reach TIMEOUT. TIMEOUT=0 disables expiry.
// Ports:
//   clock   in  system clock, rising edge
//   nreset  in  asynchronous active-low reset
//   clear   in  zero the count (takes priority over enable)
//   enable  in  advance the count this cycle
//   expire  out count reaches TIMEOUT at the next edge
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // A zero-width counter is illegal, so the disabled build keeps one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;
    localparam logic [CW-1:0] LAST_CNT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count is zero in the first busy cycle, so LAST_CNT marks the
    // TIMEOUT-th busy cycle.
    assign expire = (TIMEOUT != 0) && enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port memory
// Purpose: grants the instruction-fetch or load/store port, runs a registered
//          req/ack handshake to memory, returns read data with a one-cycle ack,
//          and aborts hung accesses with a poison word via a watchdog.
// Config:  MEM_ARB_RR_EN defined selects round-robin arbitration; undefined
//          gives fixed priority with the data port winning.
// Ports:
//   clock, nreset                 clock and asynchronous active-low reset
//   if_req/if_addr                fetch request and address
//   if_rdata/if_ack               fetch data and completion pulse
//   d_req/d_we/d_addr/d_wdata     data request, store flag, address, store data
//   d_rdata/d_ack                 load data and completion pulse
//   m_req/m_we/m_addr/m_wdata     memory request side (registered)
//   m_rdata/m_ack                 memory response side
//   grant_d                       last grant went to the data port
//   timeout                       sticky abort flag, cleared only by reset
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int              AW      = 32,
    parameter int              DW      = 32,
    parameter int              TIMEOUT = 16,
    parameter logic [DW-1:0]   POISON  = DW'(DEFAULT_POISON)
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          grant_d,
    output logic          timeout
);

    state_t        state_q, state_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_ack_q, d_ack_d;
    logic          grant_d_q, grant_d_d;
    logic          timeout_q, timeout_d;
    logic          pick_d;
    logic          busy;
    logic          wd_expire;
    logic          finish;
    logic [DW-1:0] finish_data;

`ifdef MEM_ARB_RR_EN
    port_t         rr_last_q, rr_last_d;
`endif

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_D);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .nreset (nreset),
        .clear  (!busy),
        .enable (busy),
        .expire (wd_expire)
    );

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // Contention goes to the port not granted last; a lone request wins.
        pick_d = d_req && (!if_req || (rr_last_q == PORT_IF));
`else
        // The load/store belongs to the older instruction, so it goes first.
        pick_d = d_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        if_ack_d   = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_ack_d    = 1'b0;
        grant_d_d  = grant_d_q;
        timeout_d  = timeout_q;
`ifdef MEM_ARB_RR_EN
        rr_last_d  = rr_last_q;
`endif

        // m_ack beats a same-cycle watchdog expiry.
        finish      = m_ack || wd_expire;
        finish_data = m_ack ? m_rdata : POISON;

        case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    m_req_d   = 1'b1;
                    grant_d_d = pick_d;
`ifdef MEM_ARB_RR_EN
                    rr_last_d = pick_d ? PORT_D : PORT_IF;
`endif
                    if (pick_d) begin
                        state_d   = BUSY_D;
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        state_d   = BUSY_IF;
                        m_we_d    = 1'b0;
                        m_addr_d  = if_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                if (finish) begin
                    m_req_d = 1'b0;
                    state_d = DONE;
                    if (!m_ack) begin
                        timeout_d = 1'b1;
                    end
                    if (state_q == BUSY_D) begin
                        d_rdata_d = finish_data;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = finish_data;
                        if_ack_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_ack_q    <= 1'b0;
            grant_d_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= PORT_IF;
`endif
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            if_ack_q   <= if_ack_d;
            d_rdata_q  <= d_rdata_d;
            d_ack_q    <= d_ack_d;
            grant_d_q  <= grant_d_d;
            timeout_q  <= timeout_d;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign if_ack   = if_ack_q;
    assign d_rdata  = d_rdata_q;
    assign d_ack    = d_ack_q;
    assign grant_d  = grant_d_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int          AW      = 32;
    localparam int          DW      = 32;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] POISON  = 32'hDEADBEEF;

    logic          clock = 1'b0;
    logic          nreset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          grant_d;
    logic          timeout;

    always #5 clock = ~clock;

    mem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .POISON  (POISON)
    ) dut (
        .clock    (clock),
        .nreset   (nreset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .grant_d  (grant_d),
        .timeout  (timeout)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t grant_q[$];
    txn_t ack_q[$];

    int   errors = 0;
    int   checks = 0;
    int   mem_mode = 0;      // 0: ack one cycle after m_req, 1: never, 2: ack in TIMEOUT-th cycle
    int   mreq_cycles = 0;
    int   mreq_run = 0;
    logic m_req_prev = 1'b0;
    int   ack_count = 0;
    logic ack_seen = 1'b0;
    logic last_ack_port = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h2402000A + (a - 32'h100);
    endfunction

    function automatic txn_t mk(input logic port, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input txn_t t, input logic want_ack);
        grant_q.push_back(t);
        if (want_ack) ack_q.push_back(t);
    endtask

    // One clock: observe outputs after the edge, score them, then play memory.
    task automatic cycle();
        txn_t e;
        @(posedge clock);
        #1;
        ack_seen = 1'b0;
        if (m_req && !m_req_prev) begin
            if (grant_q.size() == 0) begin
                chk("unexpected_mreq", 32'(m_req), 32'd0);
            end else begin
                e = grant_q.pop_front();
                chk("grant_port", 32'(grant_d), 32'(e.port));
                chk("grant_we", 32'(m_we), 32'(e.we));
                chk("grant_addr", m_addr, e.addr);
                if (e.we) chk("grant_wdata", m_wdata, e.wdata);
            end
        end
        if (m_req) begin
            mreq_cycles = m_req_prev ? mreq_cycles + 1 : 1;
        end else begin
            if (m_req_prev) mreq_run = mreq_cycles;
            mreq_cycles = 0;
        end
        m_req_prev = m_req;
        if (if_ack || d_ack) begin
            ack_seen = 1'b1;
            ack_count++;
            last_ack_port = d_ack;
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {30'd0, if_ack, d_ack}, 32'd0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_both", 32'(if_ack && d_ack), 32'd0);
                chk("ack_port", 32'(d_ack), 32'(e.port));
                chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
            end
            if (d_ack) d_req = 1'b0;
            if (if_ack) if_req = 1'b0;
        end
        case (mem_mode)
            0:       m_ack = m_req && (mreq_cycles == 2);
            2:       m_ack = m_req && (mreq_cycles == TIMEOUT);
            default: m_ack = 1'b0;
        endcase
        m_rdata = m_ack ? mem_data(m_addr) : 32'h0BAD0BAD;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag, output int used);
        int start;
        start = ack_count;
        used = 0;
        while ((ack_count - start) < n && used < budget) begin
            cycle();
            used++;
        end
        chk(tag, ack_count - start, n);
    endtask

    initial begin
        int used;
        int n_pairs;
        int if_issued;
        int d_issued;
        int start;

        // 1: reset held with both requesters active
        nreset = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        repeat (4) begin
            @(posedge clock);
            #1;
            chk("rst_mreq", 32'(m_req), 32'd0);
            chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        end
        chk("rst_flags", {29'd0, m_we, grant_d, timeout}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mwdata", m_wdata, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        nreset = 1'b1;
        cycle();
        cycle();
        chk("idle_after_rst", 32'(m_req), 32'd0);

        // 2: lone fetch, 1-cycle memory
        if_addr = 32'h100; if_req = 1'b1;
        push(mk(1'b0, 1'b0, 32'h100, 32'd0, 32'h2402000A), 1'b1);
        wait_acks(1, 20, "t2_fetch_done", used);
        chk("t2_latency", used, 3);

        // 3: simultaneous fetch and store
        n_pairs = 1;
`ifdef MEM_ARB_RR_EN
        n_pairs = 4;
`endif
        for (int k = 0; k < n_pairs; k++) begin
            push(mk(1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'h55 + 32'(k), mem_data(32'h200 + 32'(4 * k))), 1'b1);
            push(mk(1'b0, 1'b0, 32'h104 + 32'(4 * k), 32'd0, mem_data(32'h104 + 32'(4 * k))), 1'b1);
        end
        if_addr = 32'h104; if_req = 1'b1;
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; d_req = 1'b1;
        if_issued = 1; d_issued = 1;
        start = ack_count;
        for (int c = 0; c < 200 && (ack_count - start) < 2 * n_pairs; c++) begin
            cycle();
            if (ack_seen && last_ack_port && d_issued < n_pairs) begin
                d_addr = 32'h200 + 32'(4 * d_issued);
                d_wdata = 32'h55 + 32'(d_issued);
                d_req = 1'b1;
                d_issued++;
            end
            if (ack_seen && !last_ack_port && if_issued < n_pairs) begin
                if_addr = 32'h104 + 32'(4 * if_issued);
                if_req = 1'b1;
                if_issued++;
            end
        end
        chk("t3_pairs_done", ack_count - start, 2 * n_pairs);

        // 5: m_ack lands in the same cycle the watchdog expires
        mem_mode = 2;
        d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
        push(mk(1'b1, 1'b0, 32'h300, 32'd0, mem_data(32'h300)), 1'b1);
        wait_acks(1, 40, "t5_done", used);
        chk("t5_mreq_len", mreq_run, TIMEOUT);
        chk("t5_timeout", 32'(timeout), 32'd0);

        // 4: memory never acks
        mem_mode = 1;
        d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
        push(mk(1'b1, 1'b0, 32'h400, 32'd0, POISON), 1'b1);
        wait_acks(1, 40, "t4_abort_done", used);
        chk("t4_mreq_len", mreq_run, TIMEOUT);
        chk("t4_timeout_set", 32'(timeout), 32'd1);
        mem_mode = 0;
        repeat (3) cycle();
        chk("t4_timeout_sticky", 32'(timeout), 32'd1);
        if_addr = 32'h108; if_req = 1'b1;
        push(mk(1'b0, 1'b0, 32'h108, 32'd0, mem_data(32'h108)), 1'b1);
        wait_acks(1, 20, "t4_next_done", used);
        chk("t4_next_latency", used, 3);
        chk("t4_timeout_kept", 32'(timeout), 32'd1);

        // 6: reset in the middle of a data access
        mem_mode = 1;
        d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h77; d_req = 1'b1;
        push(mk(1'b1, 1'b1, 32'h500, 32'h77, 32'd0), 1'b0);
        repeat (4) cycle();
        chk("t6_busy", 32'(m_req), 32'd1);
        nreset = 1'b0;
        d_req = 1'b0;
        #1;
        chk("t6_mreq_drop", 32'(m_req), 32'd0);
        chk("t6_timeout_clr", 32'(timeout), 32'd0);
        cycle();
        cycle();
        nreset = 1'b1;
        mem_mode = 0;
        repeat (6) cycle();
        chk("t6_idle", {30'd0, m_req, d_ack}, 32'd0);

        chk("grant_q_empty", grant_q.size(), 32'd0);
        chk("ack_q_empty", ack_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
